wb_result_arbiter: RTL and testbench
====================================

// Module: wb_result_arbiter
// PURPOSE
//  Writeback-stage arbiter feeding the single register-file write port and the forwarding unit.
//  Merges single-cycle ALU results with out-of-order-latency FP-unit results.
//  FP results are buffered in a small FIFO; one result is retired per cycle.
//  Outputs WA3W/RegWriteW/ResultW directly drive regfile write and forwarding match.
// PARAMETERS
//  DATA_W       32  result width
//  ADDR_W       4   register address width (16 regs)
//  FIFO_DEPTH   4   FP result buffer entries (power of 2, >=2)
//  STARVE_LIMIT 3   cycles FIFO head may wait before ALU is stalled
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high reset
//  alu_valid    in   1       ALU result present this cycle (never back-pressured except via alu_stall)
//  alu_wa       in   ADDR_W  ALU destination register
//  alu_result   in   DATA_W  ALU result
//  alu_stall    out  1       upstream must hold ALU result next cycle (starvation guard)
//  fp_valid     in   1       FP result offered
//  fp_ready     out  1       FIFO can accept (count < FIFO_DEPTH)
//  fp_wa        in   ADDR_W  FP destination register
//  fp_result    in   DATA_W  FP result
//  WA3W         out  ADDR_W  writeback address (registered)
//  RegWriteW    out  1       writeback enable (registered)
//  ResultW      out  DATA_W  writeback data (registered)
//  fifo_count   out  $clog2(FIFO_DEPTH)+1  entries held
// BEHAVIOUR
//  - Reset: WA3W=0, RegWriteW=0, ResultW=0, alu_stall=0, fifo_count=0, age=0, FIFO ptrs=0; in-flight entries discarded.
//  - FP accept: fp_valid & fp_ready at edge. fp_ready combinational = (fifo_count < FIFO_DEPTH); a same-cycle pop does not raise it.
//  - Select per cycle: if alu_valid & !alu_stall -> ALU wins; else if FIFO non-empty -> pop head; else idle.
//  - Output register loads selection at edge; RegWriteW=0 when idle (WA3W/ResultW hold last value).
//  - Latency: ALU 1 cycle. FP 2 cycles min (enqueue N, pop N+1, RegWriteW at N+2).
//  - Simultaneous push and pop: both occur, count unchanged; push to full FIFO never happens (fp_ready=0).
//  - Pointers wrap modulo FIFO_DEPTH; FIFO order strictly preserved.
//  - Starvation: age counter increments each cycle FIFO non-empty and head not popped; clears on pop or empty.
//    age >= STARVE_LIMIT -> alu_stall=1 (registered) next cycle; that cycle head is popped; alu_stall drops after.
//    While alu_stall=1, alu_valid inputs are ignored (upstream holds them).
//  - WAW ordering between ALU and FP targets is guaranteed by issue scoreboard upstream; not checked here.
// CONFIGURATION
//  WB_FP_BYPASS_EN defined: FIFO empty, no ALU winner, fp_valid -> FP result goes straight into
//    output register without enqueue; FP latency 1 cycle; fifo_count stays 0.
//  Undefined: every FP result enqueues; 2-cycle minimum latency.
// STRUCTURE
//  wb_pkg: DATA_W, ADDR_W constants; typedef struct packed {logic [ADDR_W-1:0] wa; logic [DATA_W-1:0] data;} wb_entry_t.
//  Sub-module wb_fifo: FIFO_DEPTH x wb_entry_t, push/pop/count/empty/full, async reset.
//  Top holds select mux, age counter, alu_stall reg, output registers.
// TESTING
//  1 reset mid-stream with 3 FIFO entries -> RegWriteW=0, fifo_count=0, alu_stall=0 immediately; nothing retired after.
//  2 ALU only: alu_valid, alu_wa=5, alu_result=0x3F800000 -> next edge WA3W=5, RegWriteW=1, ResultW=0x3F800000.
//  3 FP only (no bypass): fp push wa=2 data=0x40000000 at N -> RegWriteW=1, WA3W=2 at N+2; with WB_FP_BYPASS_EN at N+1.
//  4 Fill: 4 FP pushes while alu_valid held high -> fifo_count=4, fp_ready=0; 5th fp_valid not accepted.
//  5 Starvation: FIFO head + continuous ALU, STARVE_LIMIT=3 -> alu_stall=1 for one cycle, head retired in order.
//  6 Push+pop same cycle with count=2 -> count stays 2, retire order matches push order across pointer wrap.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_pkg : shared widths, FIFO entry type and writeback source select
// Revision 1.0
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_IDLE   = 2'd0,
    SEL_ALU    = 2'd1,
    SEL_FIFO   = 2'd2,
    SEL_BYPASS = 2'd3
  } wb_sel_e;

  function automatic wb_entry_t make_entry(input logic [ADDR_W-1:0] wa,
                                           input logic [DATA_W-1:0] data);
    wb_entry_t e;
    e.wa   = wa;
    e.data = data;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_fifo : DEPTH-entry FP result buffer, head visible combinationally
// Revision 1.0
// ---------------------------------------------------------------------------
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wb_entry_t              push_data,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_result_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_result_arbiter : merges ALU and buffered FP results onto one writeback port
// Optional WB_FP_BYPASS_EN: idle-cycle FP results skip the FIFO (1-cycle latency)
// Revision 1.0
// ---------------------------------------------------------------------------
module wb_result_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_valid,
  input  logic [ADDR_W-1:0]           alu_wa,
  input  logic [DATA_W-1:0]           alu_result,
  output logic                        alu_stall,
  input  logic                        fp_valid,
  output logic                        fp_ready,
  input  logic [ADDR_W-1:0]           fp_wa,
  input  logic [DATA_W-1:0]           fp_result,
  output logic [ADDR_W-1:0]           WA3W,
  output logic                        RegWriteW,
  output logic [DATA_W-1:0]           ResultW,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1) + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  wb_sel_e          sel;
  wb_entry_t        fifo_head;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_push;
  logic             fifo_pop;
  logic [AGE_W-1:0] age;
  logic [AGE_W-1:0] age_next;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (make_entry(fp_wa, fp_result)),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    sel = SEL_IDLE;
    if (alu_valid && !alu_stall) begin
      sel = SEL_ALU;
    end else if (!fifo_empty) begin
      sel = SEL_FIFO;
    end
`ifdef WB_FP_BYPASS_EN
    else if (fp_valid) begin
      sel = SEL_BYPASS;
    end
`endif
  end

  // fp_ready reflects registered occupancy only; a same-cycle pop does not free a slot.
  assign fp_ready  = !fifo_full;
  assign fifo_pop  = (sel == SEL_FIFO);
  assign fifo_push = fp_valid && fp_ready && (sel != SEL_BYPASS);

  always_comb begin
    age_next = age;
    if (fifo_empty || fifo_pop) begin
      age_next = '0;
    end else if (age < AGE_MAX) begin
      age_next = age + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age       <= '0;
      alu_stall <= 1'b0;
      WA3W      <= '0;
      RegWriteW <= 1'b0;
      ResultW   <= '0;
    end else begin
      age       <= age_next;
      // The stall cycle always pops the head, so the stall self-clears after one cycle.
      alu_stall <= (age >= AGE_MAX) && !fifo_pop;
      case (sel)
        SEL_ALU: begin
          RegWriteW <= 1'b1;
          WA3W      <= alu_wa;
          ResultW   <= alu_result;
        end
        SEL_FIFO: begin
          RegWriteW <= 1'b1;
          WA3W      <= fifo_head.wa;
          ResultW   <= fifo_head.data;
        end
        SEL_BYPASS: begin
          RegWriteW <= 1'b1;
          WA3W      <= fp_wa;
          ResultW   <= fp_result;
        end
        default: begin
          RegWriteW <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_result_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_result_arbiter : directed scenarios plus randomized traffic vs queue model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_wb_result_arbiter;
  import wb_pkg::*;

  localparam int FIFO_DEPTH   = 4;
  localparam int STARVE_LIMIT = 3;
  localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;

  logic              clk;
  logic              reset;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_wa;
  logic [DATA_W-1:0] alu_result;
  logic              alu_stall;
  logic              fp_valid;
  logic              fp_ready;
  logic [ADDR_W-1:0] fp_wa;
  logic [DATA_W-1:0] fp_result;
  logic [ADDR_W-1:0] WA3W;
  logic              RegWriteW;
  logic [DATA_W-1:0] ResultW;
  logic [CNT_W-1:0]  fifo_count;

  wb_result_arbiter #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_wa     (alu_wa),
    .alu_result (alu_result),
    .alu_stall  (alu_stall),
    .fp_valid   (fp_valid),
    .fp_ready   (fp_ready),
    .fp_wa      (fp_wa),
    .fp_result  (fp_result),
    .WA3W       (WA3W),
    .RegWriteW  (RegWriteW),
    .ResultW    (ResultW),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending FP results in arrival order, cycles the oldest has waited.
  logic [ADDR_W+DATA_W-1:0] m_q[$];
  int                       m_wait;
  bit                       m_stall;
  bit                       m_we;
  logic [ADDR_W-1:0]        m_wa;
  logic [DATA_W-1:0]        m_res;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_wait  = 0;
    m_stall = 0;
    m_we    = 0;
    m_wa    = '0;
    m_res   = '0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_we"},    64'(RegWriteW),  64'(m_we));
    check({pfx, "_wa"},    64'(WA3W),       64'(m_wa));
    check({pfx, "_res"},   64'(ResultW),    64'(m_res));
    check({pfx, "_count"}, 64'(fifo_count), 64'(m_q.size()));
    check({pfx, "_stall"}, 64'(alu_stall),  64'(m_stall));
  endtask

  // One clock: drive inputs at negedge, advance the model, check at the next negedge.
  task automatic step(input bit av, input logic [ADDR_W-1:0] awa, input logic [DATA_W-1:0] ares,
                      input bit fv, input logic [ADDR_W-1:0] fwa, input logic [DATA_W-1:0] fres);
    bit alu_win, ready, pop, bypass, push;
    logic [ADDR_W+DATA_W-1:0] head;
    alu_valid  = av;
    alu_wa     = awa;
    alu_result = ares;
    fp_valid   = fv;
    fp_wa      = fwa;
    fp_result  = fres;
    #1;
    ready = (m_q.size() < FIFO_DEPTH);
    check("fp_ready", 64'(fp_ready), 64'(ready));

    alu_win = av && !m_stall;
    pop     = !alu_win && (m_q.size() != 0);
`ifdef WB_FP_BYPASS_EN
    bypass  = !alu_win && (m_q.size() == 0) && fv;
`else
    bypass  = 0;
`endif
    push    = fv && ready && !bypass;

    if (alu_win) begin
      m_we = 1; m_wa = awa; m_res = ares;
    end else if (pop) begin
      head = m_q[0];
      m_we = 1; m_wa = head[ADDR_W+DATA_W-1:DATA_W]; m_res = head[DATA_W-1:0];
    end else if (bypass) begin
      m_we = 1; m_wa = fwa; m_res = fres;
    end else begin
      m_we = 0;
    end
    m_stall = (m_wait >= STARVE_LIMIT) && !pop;
    if (m_q.size() == 0 || pop) m_wait = 0;
    else m_wait++;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back({fwa, fres});

    @(posedge clk);
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic idle();
    step(0, '0, '0, 0, '0, '0);
  endtask

  int stall_pulses;
  bit av_r;
  logic [ADDR_W-1:0] awa_r;
  logic [DATA_W-1:0] ares_r;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    alu_valid = 0; alu_wa = '0; alu_result = '0;
    fp_valid = 0;  fp_wa = '0;  fp_result = '0;
    model_reset();
    #3;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    idle();

    // ALU only
    step(1, 4'd5, 32'h3F80_0000, 0, '0, '0);
    check("alu_wa",  64'(WA3W),      64'd5);
    check("alu_we",  64'(RegWriteW), 64'd1);
    check("alu_res", 64'(ResultW),   64'h3F80_0000);
    idle();

    // FP only
    step(0, '0, '0, 1, 4'd2, 32'h4000_0000);
`ifdef WB_FP_BYPASS_EN
    check("fp_lat1_we", 64'(RegWriteW), 64'd1);
    check("fp_lat1_wa", 64'(WA3W),      64'd2);
    check("fp_bypass_count", 64'(fifo_count), 64'd0);
`else
    check("fp_lat1_we", 64'(RegWriteW), 64'd0);
    idle();
    check("fp_lat2_we",  64'(RegWriteW), 64'd1);
    check("fp_lat2_wa",  64'(WA3W),      64'd2);
    check("fp_lat2_res", 64'(ResultW),   64'h4000_0000);
`endif
    idle();

    // Fill while ALU holds the port
    for (int i = 0; i < 4; i++) step(1, 4'(i + 8), $urandom, 1, 4'(i), 32'hF000_0000 + i);
    check("fill_count", 64'(fifo_count), 64'd4);
    check("fill_ready", 64'(fp_ready),   64'd0);
    step(1, 4'd9, 32'h1234, 1, 4'd15, 32'hDEAD_BEEF);
    for (int i = 0; i < 8; i++) idle();
    check("fill_drained", 64'(fifo_count), 64'd0);

    // Starvation: one head entry against continuous ALU traffic
    stall_pulses = 0;
    step(1, 4'd1, 32'h11, 1, 4'd7, 32'h7777_7777);
    for (int i = 0; i < 8; i++) begin
      step(1, 4'd1, 32'h100 + i, 0, '0, '0);
      if (alu_stall) stall_pulses++;
    end
    check("starve_pulses", 64'(stall_pulses), 64'd1);
    check("starve_drained", 64'(fifo_count), 64'd0);
    idle();

    // Simultaneous push and pop at count 2 across pointer wrap
    step(1, 4'd3, 32'h33, 1, 4'd10, 32'hA0);
    step(1, 4'd3, 32'h34, 1, 4'd11, 32'hA1);
    for (int i = 0; i < 6; i++) begin
      step(0, '0, '0, 1, 4'(12 + i), 32'hA2 + i);
      check("pp_count", 64'(fifo_count), 64'd2);
    end
    idle(); idle(); idle();

    // Reset mid-stream with three entries held
    for (int i = 0; i < 3; i++) step(1, 4'd4, 32'h44 + i, 1, 4'(i), 32'hC0 + i);
    check("pre_reset_count", 64'(fifo_count), 64'd3);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) idle();

    // Randomized traffic in phases of differing ALU/FP pressure
    av_r = 0; awa_r = '0; ares_r = '0;
    for (int ph = 0; ph < 6; ph++) begin
      int ap, fpp;
      case (ph)
        0: begin ap = 0;   fpp = 50;  end
        1: begin ap = 30;  fpp = 90;  end
        2: begin ap = 100; fpp = 60;  end
        3: begin ap = 70;  fpp = 40;  end
        4: begin ap = 90;  fpp = 100; end
        default: begin ap = 50; fpp = 20; end
      endcase
      for (int c = 0; c < 250; c++) begin
        if (!m_stall) begin
          av_r   = ($urandom_range(99) < ap);
          awa_r  = 4'($urandom);
          ares_r = $urandom;
        end
        step(av_r, awa_r, ares_r, ($urandom_range(99) < fpp), 4'($urandom), $urandom);
      end
    end
    for (int i = 0; i < 8; i++) idle();
    check("final_count", 64'(fifo_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
